// File: rtl/prog_mem_loadable.sv
// rtl/prog_mem_loadable.sv - RAM-backed program memory with byte-wide handshake loader
// Zero-fills on reset, serves one registered fetch port in RUN, and assembles MSB-first symbols into words in LOAD.
module prog_mem_loadable #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              run,
    input  logic              ld_start,
    input  logic              ld_end,
    input  logic [BYTE_W-1:0] ld_byte,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic [ADDR_W:0]   ld_count,
    output logic              ld_overflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BPW   = DATA_W / BYTE_W;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] clr_ptr;
    logic [ADDR_W:0]   wr_ptr;
    logic [IDX_W-1:0]  sym_idx;
    logic [DATA_W-1:0] asm_word;
    logic [DATA_W-1:0] asm_next;
    logic              full;
    logic              accept;
    logic              word_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign full     = (wr_ptr == (ADDR_W+1)'(DEPTH));
    assign asm_next = (asm_word << BYTE_W) | DATA_W'(ld_byte);
    assign ld_count = wr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = S_RUN;
            S_RUN:   if (ld_start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (ld_start)    state_nxt = S_LOAD;
                else if (ld_end) state_nxt = S_RUN;
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    // ld_start wins over symbol acceptance, so a restart never writes a stale word
    always_comb begin
        run       = 1'b0;
        ld_ready  = 1'b0;
        accept    = 1'b0;
        word_done = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        case (state)
            S_CLEAR: mem_we = 1'b1;
            S_RUN:   run = 1'b1;
            S_LOAD: begin
                ld_ready  = !full;
                accept    = ld_valid && !full && !ld_start;
                word_done = accept && (sym_idx == IDX_W'(BPW - 1));
                mem_we    = word_done;
                mem_waddr = wr_ptr[ADDR_W-1:0];
                mem_wdata = asm_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data        <= '0;
            clr_ptr     <= '0;
            wr_ptr      <= '0;
            sym_idx     <= '0;
            asm_word    <= '0;
            ld_overflow <= 1'b0;
        end else begin
            data <= (state == S_RUN) ? mem[addr] : '0;
            if (state == S_CLEAR) clr_ptr <= clr_ptr + 1'b1;
            if (state != S_CLEAR && ld_start) begin
                wr_ptr      <= '0;
                sym_idx     <= '0;
                asm_word    <= '0;
                ld_overflow <= 1'b0;
            end else if (state == S_LOAD) begin
                if (accept) begin
                    asm_word <= asm_next;
                    if (word_done) begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        sym_idx <= '0;
                    end else begin
                        sym_idx <= sym_idx + 1'b1;
                    end
                end else if (full && ld_valid) begin
                    ld_overflow <= 1'b1;
                end
                if (ld_end) sym_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prog_mem_loadable.sv
// tb/tb_prog_mem_loadable.sv - self-checking bench for prog_mem_loadable
module tb_prog_mem_loadable;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  addr = '0;
    logic [15:0] data;
    logic        run;
    logic        ld_start = 1'b0;
    logic        ld_end = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [8:0]  ld_count;
    logic        ld_overflow;

    prog_mem_loadable #(.DATA_W(16), .ADDR_W(8), .BYTE_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .data       (data),
        .run        (run),
        .ld_start   (ld_start),
        .ld_end     (ld_end),
        .ld_byte    (ld_byte),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_count   (ld_count),
        .ld_overflow(ld_overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: word store plus load bookkeeping
    logic [15:0] m_mem [256];
    int          m_cnt;
    logic        m_half;
    logic [7:0]  m_hi;
    logic        m_ovf;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t    tbl [6];
    logic [7:0] prog [18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        m_cnt  = 0;
        m_half = 1'b0;
        m_hi   = 8'h00;
        m_ovf  = 1'b0;
    endtask

    task automatic model_start();
        m_cnt  = 0;
        m_half = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (m_cnt >= 256) begin
            m_ovf = 1'b1;
        end else if (!m_half) begin
            m_hi   = b;
            m_half = 1'b1;
        end else begin
            m_mem[m_cnt] = {m_hi, b};
            m_cnt++;
            m_half = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        check("ld_ready", 32'(ld_ready), (m_cnt < 256) ? 1 : 0);
        ld_byte  = b;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        model_accept(b);
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        model_start();
    endtask

    task automatic end_load();
        m_half = 1'b0;
        ld_end = 1'b1;
        tick();
        ld_end = 1'b0;
    endtask

    task automatic read_check(input logic [7:0] a, input logic [15:0] exp, input string name);
        addr = a;
        tick();
        check(name, 32'(data), 32'(exp));
    endtask

    // Counts cycles from reset release until run rises; optionally pokes load pulses mid-clear
    task automatic wait_clear(input bit poke);
        int n = 0;
        check("run_low_after_reset", 32'(run), 0);
        check("data_after_reset", 32'(data), 0);
        check("ld_count_after_reset", 32'(ld_count), 0);
        check("ld_overflow_after_reset", 32'(ld_overflow), 0);
        check("ld_ready_in_clear", 32'(ld_ready), 0);
        while (!run && n < 1000) begin
            if (poke && n == 5) begin
                ld_start = 1'b1;
                ld_end   = 1'b1;
                ld_valid = 1'b1;
            end
            tick();
            ld_start = 1'b0;
            ld_end   = 1'b0;
            ld_valid = 1'b0;
            n++;
        end
        check("clear_cycles", n, 256);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       v;
        int         cyc;

        prog = '{8'hF9, 8'h00, 8'hF9, 8'h11, 8'h08, 8'h12, 8'h34, 8'h01, 8'h20,
                 8'h02, 8'h4F, 8'h03, 8'h11, 8'h04, 8'hC0, 8'hFF, 8'hA5, 8'hA5};
        tbl[0] = '{8'h00, 16'hF900};
        tbl[1] = '{8'h01, 16'hF911};
        tbl[2] = '{8'h04, 16'h2002};
        tbl[3] = '{8'h08, 16'hA5A5};
        tbl[4] = '{8'h09, 16'h0000};
        tbl[5] = '{8'hFF, 16'h0000};

        // 1: reset, clear timing, zero reads
        model_reset();
        tick();
        apply_reset();
        wait_clear(1'b0);
        read_check(8'h00, 16'h0000, "t1_rd00");
        read_check(8'h7F, 16'h0000, "t1_rd7f");
        read_check(8'hFF, 16'h0000, "t1_rdff");

        // 2: program load, table-driven readback
        start_load();
        check("t2_run_in_load", 32'(run), 0);
        for (int i = 0; i < 18; i++) send_byte(prog[i]);
        end_load();
        check("t2_ld_count", 32'(ld_count), 9);
        check("t2_run", 32'(run), 1);
        for (int i = 0; i < 6; i++) begin
            read_check(tbl[i].addr, tbl[i].exp, $sformatf("t2_tbl%0d", i));
            check($sformatf("t2_model%0d", i), 32'(m_mem[tbl[i].addr]), 32'(tbl[i].exp));
        end
        ld_end = 1'b1;
        tick();
        ld_end = 1'b0;
        check("t2_ld_end_in_run", 32'(run), 1);
        check("t2_count_hold", 32'(ld_count), 9);

        // 3: random valid gaps over a 4-word load
        start_load();
        cyc = 0;
        while (m_cnt < 4 && cyc < 500) begin
            v = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            check("t3_ld_ready", 32'(ld_ready), 1);
            check("t3_data_zero_in_load", 32'(data), 0);
            ld_byte  = b;
            ld_valid = v;
            tick();
            ld_valid = 1'b0;
            if (v) model_accept(b);
            cyc++;
        end
        end_load();
        check("t3_ld_count", 32'(ld_count), 4);
        for (int i = 0; i < 5; i++)
            read_check(8'(i), m_mem[i], $sformatf("t3_rd%0d", i));
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 15));
            read_check(b, m_mem[b], $sformatf("t3_rand_rd%0h", b));
        end

        // 4: partial word discarded
        apply_reset();
        wait_clear(1'b0);
        start_load();
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        end_load();
        check("t4_ld_count", 32'(ld_count), 1);
        read_check(8'h00, 16'hAABB, "t4_rd0");
        read_check(8'h01, 16'h0000, "t4_rd1");

        // 5: fill memory, then overflow
        start_load();
        for (int i = 0; i < 512; i++) send_byte(8'($urandom));
        check("t5_ld_ready_full", 32'(ld_ready), 0);
        check("t5_ld_count_full", 32'(ld_count), 256);
        check("t5_ovf_before", 32'(ld_overflow), 0);
        send_byte(8'h5A);
        check("t5_ovf", 32'(ld_overflow), 32'(m_ovf));
        check("t5_ovf_set", 32'(ld_overflow), 1);
        end_load();
        read_check(8'hFF, m_mem[255], "t5_rdff");
        read_check(8'h00, m_mem[0], "t5_rd00");
        read_check(8'h80, m_mem[128], "t5_rd80");
        start_load();
        check("t5_ovf_cleared", 32'(ld_overflow), 0);
        check("t5_count_cleared", 32'(ld_count), 0);
        end_load();

        // 6: reset mid-load, pulses during clear, simultaneous start+end
        start_load();
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(1, 255)));
        check("t6_count5", 32'(ld_count), 5);
        apply_reset();
        wait_clear(1'b1);
        for (int i = 0; i < 256; i++)
            read_check(8'(i), 16'h0000, $sformatf("t6_zero%0h", i));
        start_load();
        send_byte(8'h12);
        send_byte(8'h34);
        check("t6_count1", 32'(ld_count), 1);
        ld_start = 1'b1;
        ld_end   = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'h55;
        tick();
        ld_start = 1'b0;
        ld_end   = 1'b0;
        ld_valid = 1'b0;
        model_start();
        check("t6_stay_load_run", 32'(run), 0);
        check("t6_restart_count", 32'(ld_count), 0);
        check("t6_restart_ready", 32'(ld_ready), 1);
        send_byte(8'hBE);
        send_byte(8'hEF);
        end_load();
        check("t6_count_final", 32'(ld_count), 1);
        read_check(8'h00, 16'hBEEF, "t6_rd0");
        read_check(8'h01, 16'h0000, "t6_rd1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
